// File: rtl/turn_input_ctrl.sv
// Per-turn move collector with countdown for the game FSM.
// Optional foul output is compiled in when FOUL_DETECT_EN is defined.
module turn_input_ctrl #(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned TURN_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic       turn_req,
  input  logic       turn,
  input  logic [2:0] p1_key,
  input  logic [2:0] p2_key,
  output logic [1:0] p1_move,
  output logic [1:0] p2_move,
  output logic       move_valid,
  output logic       timeout,
  output logic       busy,
  output logic [3:0] time_left,
`ifdef FOUL_DETECT_EN
  output logic       foul,
`endif
  output logic [1:0] state_dbg
);

  localparam int unsigned     PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]      TL_INIT    = 4'(TURN_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic          active_q;
  logic [2:0]    act_key;
  logic [1:0]    key_move;
  logic          key_hit;
  logic          tick;
  logic          in_collect;
  logic          start;
  logic          accept;
  logic          expire;

  assign in_collect = (state_q == ST_COLLECT);
  assign start      = (state_q == ST_IDLE) && turn_req && enable;
  assign act_key    = active_q ? p2_key : p1_key;
  assign key_hit    = (act_key != 3'b000);
  assign tick       = in_collect && (presc_q == PRESC_LAST);

  // Outcome pulses: move_valid and timeout each fire for one cycle, the
  // cycle after the deciding event, and are mutually exclusive by construction.
  assign accept = in_collect && enable && key_hit;
  assign expire = in_collect && enable && !key_hit && tick && (time_left == 4'd1);

  always_comb begin
    key_move = 2'd3;
    if (act_key[0])      key_move = 2'd1;
    else if (act_key[1]) key_move = 2'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (!enable)                 state_d = ST_IDLE;
        else if (accept || expire)   state_d = ST_DONE;
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    state_dbg = state_q;
  end

  // A key ends the turn outright: the timer freezes even if a tick coincides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q   <= 1'b0;
      presc_q    <= '0;
      time_left  <= '0;
      move_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      move_valid <= accept;
      timeout    <= expire;
      if (start) begin
        active_q  <= turn;
        presc_q   <= '0;
        time_left <= TL_INIT;
      end else if (in_collect) begin
        if (!enable) begin
          presc_q   <= '0;
          time_left <= '0;
        end else if (!key_hit) begin
          presc_q <= tick ? '0 : presc_q + PW'(1);
          if (tick) time_left <= time_left - 4'd1;
        end
      end else if ((state_q == ST_DONE) && !enable) begin
        time_left <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_move <= 2'd0;
      p2_move <= 2'd0;
    end else if (clear) begin
      p1_move <= 2'd0;
      p2_move <= 2'd0;
    end else if (accept) begin
      if (active_q) p2_move <= key_move;
      else          p1_move <= key_move;
    end
  end

`ifdef FOUL_DETECT_EN
  logic [2:0] oth_key;
  assign oth_key = active_q ? p1_key : p2_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) foul <= 1'b0;
    else     foul <= in_collect && (oth_key != 3'b000);
  end
`endif

endmodule

// File: tb/tb_turn_input_ctrl.sv
// Bench for turn_input_ctrl (TICK_DIV=4, TURN_TICKS=3): directed scenarios
// plus randomized traffic checked every cycle against a turn-level model.
module tb_turn_input_ctrl;

  localparam int TD = 4;
  localparam int TT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       turn_req = 1'b0;
  logic       turn = 1'b0;
  logic [2:0] p1_key = 3'b000;
  logic [2:0] p2_key = 3'b000;
  logic [1:0] p1_move, p2_move;
  logic       move_valid, timeout, busy;
  logic [3:0] time_left;
  logic [1:0] state_dbg;
`ifdef FOUL_DETECT_EN
  logic       foul;
`endif

  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  turn_input_ctrl #(.TICK_DIV(TD), .TURN_TICKS(TT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .turn_req(turn_req), .turn(turn), .p1_key(p1_key), .p2_key(p2_key),
    .p1_move(p1_move), .p2_move(p2_move), .move_valid(move_valid),
    .timeout(timeout), .busy(busy), .time_left(time_left),
`ifdef FOUL_DETECT_EN
    .foul(foul),
`endif
    .state_dbg(state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 no turn, 1 collecting, 2 closing cycle; elapsed counts cycles in the turn
  int         m_phase = 0;
  int         m_elapsed = 0;
  logic       m_act = 1'b0;
  logic [1:0] e_p1 = 2'd0, e_p2 = 2'd0;
  logic       e_mv = 1'b0, e_to = 1'b0, e_busy = 1'b0, e_foul = 1'b0;
  logic [3:0] e_tl = 4'd0;
  // scoreboard of turn outcomes: {is_timeout, player, cleared, move[1:0]}
  logic [4:0] exp_q[$];
  logic [4:0] sb_ent;

  function automatic logic [1:0] lowest_move(input logic [2:0] k);
    for (int i = 0; i < 3; i++)
      if (k[i]) return 2'(i + 1);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_act = 1'b0;
    e_p1 = 2'd0; e_p2 = 2'd0; e_mv = 1'b0; e_to = 1'b0;
    e_busy = 1'b0; e_foul = 1'b0; e_tl = 4'd0;
    exp_q.delete();
  endtask

  task automatic model_update();
    logic [2:0] mine, other;
    logic [1:0] mv;
    mine  = m_act ? p2_key : p1_key;
    other = m_act ? p1_key : p2_key;
    mv = 2'd0;
    e_mv = 1'b0; e_to = 1'b0; e_foul = 1'b0;
    if (m_phase == 0) begin
      if (turn_req && enable) begin
        m_phase = 1; m_act = turn; m_elapsed = 0; e_tl = 4'(TT);
      end
    end else if (m_phase == 1) begin
      e_foul = (other != 3'b000);
      if (!enable) begin
        m_phase = 0; e_tl = 4'd0;
      end else if (mine != 3'b000) begin
        mv = lowest_move(mine); e_mv = 1'b1; m_phase = 2;
        if (m_act) e_p2 = mv; else e_p1 = mv;
      end else if (m_elapsed == TT * TD - 1) begin
        e_to = 1'b1; e_tl = 4'd0; m_phase = 2;
      end else begin
        m_elapsed++;
        e_tl = 4'(TT - m_elapsed / TD);
      end
    end else begin
      m_phase = 0;
      if (!enable) e_tl = 4'd0;
    end
    if (clear) begin e_p1 = 2'd0; e_p2 = 2'd0; end
    if (e_mv || e_to) exp_q.push_back({e_to, m_act, clear, mv});
    e_busy = (m_phase != 0);
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_p1_move", p1_move, e_p1);
      check("cyc_p2_move", p2_move, e_p2);
      check("cyc_move_valid", move_valid, e_mv);
      check("cyc_timeout", timeout, e_to);
      check("cyc_busy", busy, e_busy);
      check("cyc_time_left", time_left, e_tl);
`ifdef FOUL_DETECT_EN
      check("cyc_foul", foul, e_foul);
`endif
      if (move_valid || timeout) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_pulse: got mv=%0d to=%0d, required no pulse (t=%0t)",
                   move_valid, timeout, $time);
        end else begin
          sb_ent = exp_q.pop_front();
          check("sb_kind", timeout, sb_ent[4]);
          if (!sb_ent[4])
            check("sb_move", sb_ent[3] ? p2_move : p1_move, sb_ent[2] ? 0 : sb_ent[1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge: drives one cycle of inputs, advances the model at
  // the posedge, and returns at the next negedge.
  task automatic step(input logic tr, input logic t, input logic [2:0] k1,
                      input logic [2:0] k2, input logic clr, input logic en);
    turn_req = tr; turn = t; p1_key = k1; p2_key = k2; clear = clr; enable = en;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    enable = 1'b1;
    // reset values
    check("rst_p1_move", p1_move, 0);
    check("rst_p2_move", p2_move, 0);
    check("rst_busy", busy, 0);
    check("rst_time_left", time_left, 0);
    check("rst_pulses", {move_valid, timeout}, 0);

    // player1 move 2'b10 two cycles after turn_req
    step(1, 0, 3'b000, 3'b000, 0, 1);
    check("p1_open_busy", busy, 1);
    check("p1_open_tl", time_left, 3);
    step(0, 0, 3'b000, 3'b000, 0, 1);
    step(0, 0, 3'b010, 3'b000, 0, 1);
    check("p1_move_val", p1_move, 2);
    check("p1_mv_pulse", move_valid, 1);
    check("p1_p2_untouched", p2_move, 0);
    step(0, 0, 3'b000, 3'b000, 0, 1);
    check("p1_busy_low", busy, 0);
    check("p1_mv_single", move_valid, 0);

    // player2 timeout: 3,2,1,0 every 4 cycles, timeout 12 cycles after entry
    step(1, 1, 3'b000, 3'b000, 0, 1);
    for (int k = 1; k <= 12; k++) begin
      idle(1);
      check("to_tl", time_left, (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0);
      check("to_pulse", timeout, (k == 12) ? 1 : 0);
      check("to_no_mv", move_valid, 0);
    end
    idle(1);
    check("to_busy_low", busy, 0);
    check("to_single", timeout, 0);

    // player2 turn: player1 key ignored, then lowest of 3'b110 wins
    step(1, 1, 3'b000, 3'b000, 0, 1);
    step(0, 0, 3'b001, 3'b000, 0, 1);
    check("wrong_key_busy", busy, 1);
    check("wrong_key_p1", p1_move, 2);
    check("wrong_key_mv", move_valid, 0);
`ifdef FOUL_DETECT_EN
    check("foul_pulse", foul, 1);
`endif
    step(0, 0, 3'b000, 3'b110, 0, 1);
    check("p2_lowest", p2_move, 2);
    check("p2_mv", move_valid, 1);
    idle(1);

    // key in the same cycle as the final tick
    step(1, 1, 3'b000, 3'b000, 0, 1);
    idle(11);
    step(0, 0, 3'b000, 3'b100, 0, 1);
    check("race_mv", move_valid, 1);
    check("race_to", timeout, 0);
    check("race_p2", p2_move, 3);
    idle(1);

    // enable drop aborts the turn
    step(1, 0, 3'b000, 3'b000, 0, 1);
    step(0, 0, 3'b000, 3'b000, 0, 1);
    step(0, 0, 3'b000, 3'b000, 0, 0);
    check("abort_busy", busy, 0);
    check("abort_tl", time_left, 0);
    check("abort_pulses", {move_valid, timeout}, 0);
    check("abort_p1", p1_move, 2);
    // turn_req while busy keeps player1 active
    step(1, 0, 3'b000, 3'b000, 0, 1);
    step(1, 1, 3'b000, 3'b000, 0, 1);
    step(0, 0, 3'b000, 3'b001, 0, 1);
    check("busy_req_p2", p2_move, 3);
    check("busy_req_mv", move_valid, 0);
    step(0, 0, 3'b100, 3'b000, 0, 1);
    check("busy_req_p1", p1_move, 3);
    idle(1);
    // clear together with an accepted move
    step(1, 1, 3'b000, 3'b000, 0, 1);
    step(0, 0, 3'b000, 3'b010, 1, 1);
    check("clr_p1", p1_move, 0);
    check("clr_p2", p2_move, 0);
    check("clr_mv", move_valid, 1);
    idle(1);

    // asynchronous reset in the middle of a turn
    step(1, 0, 3'b000, 3'b000, 0, 1);
    idle(4);
    check("mid_tl", time_left, 2);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("arst_busy", busy, 0);
    check("arst_tl", time_left, 0);
    check("arst_moves", {p1_move, p2_move}, 0);
    check("arst_pulses", {move_valid, timeout}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    check("arst_idle", busy, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 5) == 0,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
           ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 24) != 0);
    end
    idle(20);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
